m_dmem_wait: RTL and testbench

//  Parametrised successor of the dual-port byte-enable data memory. Port A is an always-ready

---
 rtl/m_dmem_wait.sv | 182 ++++++++++++++++++
 tb/tb_m_dmem_wait.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_dmem_wait.sv
// m_dmem_wait: dual-port byte-enable data memory with a configurable-latency core port.
//   Port A: always-ready loader/debug port with a 1-cycle registered read-first output.
//   Port B: core data port. A request is accepted on the edge where B_REQ & B_GNT are both high.
//           After acceptance, B_RVALID pulses LATENCY cycles later with the read data (for a
//           write, the word value before the write) and B_ERR for out-of-range addresses.
// Ports:
//   CLK, RST_X                          clock, synchronous active-low reset
//   A_EN, A_WE, A_ADDR, A_IDATA         port A enable, byte write enables, word index, write data
//   A_ODATA                             port A read data (registered)
//   B_REQ, B_WE, B_ADDR, B_IDATA        port B request, byte write enables (0 = read), index, data
//   B_GNT                               port B ready
//   B_RVALID, B_RDATA, B_ERR            port B response pulse, read data, address error
module m_dmem_wait #(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned ENTRY   = 256,
  parameter  int unsigned LATENCY = 1,
  localparam int unsigned NB      = WIDTH / 8,
  localparam int unsigned AW      = (ENTRY > 1) ? $clog2(ENTRY) : 1
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             A_EN,
  input  logic [NB-1:0]    A_WE,
  input  logic [AW-1:0]    A_ADDR,
  input  logic [WIDTH-1:0] A_IDATA,
  output logic [WIDTH-1:0] A_ODATA,
  input  logic             B_REQ,
  input  logic [NB-1:0]    B_WE,
  input  logic [AW-1:0]    B_ADDR,
  input  logic [WIDTH-1:0] B_IDATA,
  output logic             B_GNT,
  output logic             B_RVALID,
  output logic [WIDTH-1:0] B_RDATA,
  output logic             B_ERR
);

  // Parameter sanity checks at elaboration.
  if ((WIDTH == 0) || ((WIDTH % 8) != 0)) begin : g_bad_width
    $error("m_dmem_wait: WIDTH must be a non-zero multiple of 8");
  end
  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_bad_latency
    $error("m_dmem_wait: LATENCY must be in 1..8");
  end

  localparam logic [2:0] CNT_INIT = 3'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [WIDTH-1:0] mem [ENTRY];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic [NB-1:0]    r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_idata;
  logic             r_b_rvalid;
  logic [WIDTH-1:0] r_b_rdata;
  logic             r_b_err;
  logic [WIDTH-1:0] r_a_odata;

  logic             w_accept;
  logic             w_acc_do;
  logic [NB-1:0]    w_acc_we;
  logic [AW-1:0]    w_acc_addr;
  logic [WIDTH-1:0] w_acc_idata;
  logic             w_acc_in;
  logic             w_a_in;
  logic             w_a_wr;
  logic             w_b_wr;
  logic [WIDTH-1:0] w_a_mask;
  logic [WIDTH-1:0] w_b_mask;
  logic [WIDTH-1:0] w_a_word;
  logic [WIDTH-1:0] w_b_base;
  logic [WIDTH-1:0] w_b_word;

  assign B_GNT    = RST_X & ((r_state == S_IDLE) || (r_state == S_RESP));
  assign w_accept = B_REQ & B_GNT;

  // Next-state logic; also selects whether the access uses live inputs or captured registers.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_do    = 1'b0;
    w_acc_we    = B_WE;
    w_acc_addr  = B_ADDR;
    w_acc_idata = B_IDATA;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_acc_do    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_acc_we    = r_we;
        w_acc_addr  = r_addr;
        w_acc_idata = r_idata;
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_RESP;
          w_acc_do    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_a_in   = (32'(A_ADDR) < ENTRY);
  assign w_acc_in = (32'(w_acc_addr) < ENTRY);
  assign w_a_wr   = RST_X & A_EN & w_a_in & (|A_WE);
  assign w_b_wr   = RST_X & w_acc_do & w_acc_in & (|w_acc_we);

  // Expand byte enables into bit masks.
  for (genvar g = 0; g < NB; g++) begin : g_mask
    assign w_a_mask[g*8 +: 8] = {8{A_WE[g]}};
    assign w_b_mask[g*8 +: 8] = {8{w_acc_we[g]}};
  end

  // On a same-word collision, B merges on top of A's merged word so B wins shared bytes.
  always_comb begin
    w_a_word = (mem[A_ADDR] & ~w_a_mask) | (A_IDATA & w_a_mask);
    w_b_base = (w_a_wr && (A_ADDR == w_acc_addr)) ? w_a_word : mem[w_acc_addr];
    w_b_word = (w_b_base & ~w_b_mask) | (w_acc_idata & w_b_mask);
  end

  // Memory array, never reset. B's write is issued last so it overrides A on the same word.
  always_ff @(posedge CLK) begin
    if (w_a_wr) mem[A_ADDR] <= w_a_word;
    if (w_b_wr) mem[w_acc_addr] <= w_b_word;
  end

  // State, request capture and response registers.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_we       <= '0;
      r_addr     <= '0;
      r_idata    <= '0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= '0;
      r_b_err    <= 1'b0;
      r_a_odata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= B_WE;
        r_addr  <= B_ADDR;
        r_idata <= B_IDATA;
      end
      r_b_rvalid <= w_acc_do;
      r_b_err    <= w_acc_do & ~w_acc_in;
      if (w_acc_do) begin
        r_b_rdata <= w_acc_in ? mem[w_acc_addr] : '0;
      end
      if (A_EN) begin
        r_a_odata <= w_a_in ? mem[A_ADDR] : '0;
      end
    end
  end

  assign A_ODATA  = r_a_odata;
  assign B_RVALID = r_b_rvalid;
  assign B_RDATA  = r_b_rdata;
  assign B_ERR    = r_b_err;

endmodule

// File: tb/tb_m_dmem_wait.sv
// tb_m_dmem_wait: directed self-checking bench for m_dmem_wait.
//   d1  : WIDTH=32 ENTRY=256 LATENCY=1 (full-throughput reads, collision)
//   d4  : WIDTH=32 ENTRY=200 LATENCY=4 (wait states, out-of-range address)
//   d3  : WIDTH=32 ENTRY=256 LATENCY=3 (reset while a write is outstanding)
//   d64 : WIDTH=64 ENTRY=256 LATENCY=1 (byte lane 7 write)
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_m_dmem_wait;

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;

  always #5 clk = ~clk;

  logic        a1_en, b1_req, b1_gnt, b1_rvalid, b1_err;
  logic [3:0]  a1_we, b1_we;
  logic [7:0]  a1_addr, b1_addr;
  logic [31:0] a1_idata, a1_odata, b1_idata, b1_rdata;

  logic        a4_en, b4_req, b4_gnt, b4_rvalid, b4_err;
  logic [3:0]  a4_we, b4_we;
  logic [7:0]  a4_addr, b4_addr;
  logic [31:0] a4_idata, a4_odata, b4_idata, b4_rdata;

  logic        a3_en, b3_req, b3_gnt, b3_rvalid, b3_err;
  logic [3:0]  a3_we, b3_we;
  logic [7:0]  a3_addr, b3_addr;
  logic [31:0] a3_idata, a3_odata, b3_idata, b3_rdata;

  logic        a64_en, b64_req, b64_gnt, b64_rvalid, b64_err;
  logic [7:0]  a64_we, b64_we;
  logic [7:0]  a64_addr, b64_addr;
  logic [63:0] a64_idata, a64_odata, b64_idata, b64_rdata;

  int checks = 0;
  int errors = 0;

  m_dmem_wait #(.WIDTH(32), .ENTRY(256), .LATENCY(1)) d1 (
    .CLK(clk), .RST_X(rst_n),
    .A_EN(a1_en), .A_WE(a1_we), .A_ADDR(a1_addr), .A_IDATA(a1_idata), .A_ODATA(a1_odata),
    .B_REQ(b1_req), .B_WE(b1_we), .B_ADDR(b1_addr), .B_IDATA(b1_idata),
    .B_GNT(b1_gnt), .B_RVALID(b1_rvalid), .B_RDATA(b1_rdata), .B_ERR(b1_err)
  );

  m_dmem_wait #(.WIDTH(32), .ENTRY(200), .LATENCY(4)) d4 (
    .CLK(clk), .RST_X(rst_n),
    .A_EN(a4_en), .A_WE(a4_we), .A_ADDR(a4_addr), .A_IDATA(a4_idata), .A_ODATA(a4_odata),
    .B_REQ(b4_req), .B_WE(b4_we), .B_ADDR(b4_addr), .B_IDATA(b4_idata),
    .B_GNT(b4_gnt), .B_RVALID(b4_rvalid), .B_RDATA(b4_rdata), .B_ERR(b4_err)
  );

  m_dmem_wait #(.WIDTH(32), .ENTRY(256), .LATENCY(3)) d3 (
    .CLK(clk), .RST_X(rst3_n),
    .A_EN(a3_en), .A_WE(a3_we), .A_ADDR(a3_addr), .A_IDATA(a3_idata), .A_ODATA(a3_odata),
    .B_REQ(b3_req), .B_WE(b3_we), .B_ADDR(b3_addr), .B_IDATA(b3_idata),
    .B_GNT(b3_gnt), .B_RVALID(b3_rvalid), .B_RDATA(b3_rdata), .B_ERR(b3_err)
  );

  m_dmem_wait #(.WIDTH(64), .ENTRY(256), .LATENCY(1)) d64 (
    .CLK(clk), .RST_X(rst_n),
    .A_EN(a64_en), .A_WE(a64_we), .A_ADDR(a64_addr), .A_IDATA(a64_idata), .A_ODATA(a64_odata),
    .B_REQ(b64_req), .B_WE(b64_we), .B_ADDR(b64_addr), .B_IDATA(b64_idata),
    .B_GNT(b64_gnt), .B_RVALID(b64_rvalid), .B_RDATA(b64_rdata), .B_ERR(b64_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    a1_en = 0; a1_we = '0; a1_addr = '0; a1_idata = '0;
    b1_req = 0; b1_we = '0; b1_addr = '0; b1_idata = '0;
    a4_en = 0; a4_we = '0; a4_addr = '0; a4_idata = '0;
    b4_req = 0; b4_we = '0; b4_addr = '0; b4_idata = '0;
    a3_en = 0; a3_we = '0; a3_addr = '0; a3_idata = '0;
    b3_req = 0; b3_we = '0; b3_addr = '0; b3_idata = '0;
    a64_en = 0; a64_we = '0; a64_addr = '0; a64_idata = '0;
    b64_req = 0; b64_we = '0; b64_addr = '0; b64_idata = '0;

    for (int i = 0; i < 256; i++) begin
      d1.mem[i]  = '0;
      d3.mem[i]  = '0;
      d64.mem[i] = '0;
    end
    for (int i = 0; i < 200; i++) d4.mem[i] = '0;
    d1.mem[4]  = 32'h44444444;
    d1.mem[5]  = 32'h55555555;
    d1.mem[9]  = 32'h11223344;
    d3.mem[2]  = 32'hCAFEF00D;
    d64.mem[1] = 64'h0123456789ABCDEF;

    // Reset state
    #1;
    chk("rst_gnt_low", 64'(b1_gnt), 64'd0);
    tick();
    tick();
    chk("rst_rvalid", 64'(b1_rvalid), 64'd0);
    chk("rst_rdata", 64'(b1_rdata), 64'd0);
    chk("rst_err", 64'(b1_err), 64'd0);
    chk("rst_a_odata", 64'(a1_odata), 64'd0);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    #1;
    chk("gnt_after_rst", 64'(b1_gnt), 64'd1);

    // LATENCY=1: A write then back-to-back B reads
    a1_en = 1; a1_we = 4'hF; a1_addr = 8'd3; a1_idata = 32'hDEADBEEF;
    tick();
    chk("t1_a_read_first", 64'(a1_odata), 64'd0);
    a1_en = 0; a1_we = '0;
    b1_req = 1; b1_we = '0; b1_addr = 8'd3;
    tick();
    chk("t1_rvalid", 64'(b1_rvalid), 64'd1);
    chk("t1_rdata", 64'(b1_rdata), 64'hDEADBEEF);
    chk("t1_err", 64'(b1_err), 64'd0);
    chk("t1_gnt_resp", 64'(b1_gnt), 64'd1);
    b1_addr = 8'd4;
    tick();
    chk("t1_b2b_rvalid4", 64'(b1_rvalid), 64'd1);
    chk("t1_b2b_rdata4", 64'(b1_rdata), 64'h44444444);
    b1_addr = 8'd5;
    tick();
    chk("t1_b2b_rdata5", 64'(b1_rdata), 64'h55555555);
    b1_req = 0;
    tick();
    chk("t1_rvalid_drop", 64'(b1_rvalid), 64'd0);
    chk("t1_rdata_hold", 64'(b1_rdata), 64'h55555555);

    // Collision on word 9
    a1_en = 1; a1_we = 4'hF; a1_addr = 8'd9; a1_idata = 32'hAAAAAAAA;
    b1_req = 1; b1_we = 4'b0001; b1_addr = 8'd9; b1_idata = 32'h000000BB;
    tick();
    chk("t3_a_old", 64'(a1_odata), 64'h11223344);
    chk("t3_b_old", 64'(b1_rdata), 64'h11223344);
    chk("t3_b_rvalid", 64'(b1_rvalid), 64'd1);
    a1_we = '0; b1_req = 0; b1_we = '0;
    tick();
    chk("t3_merged", 64'(a1_odata), 64'hAAAAAABB);
    a1_en = 0;

    // LATENCY=4: partial write with wait states; garbage on inputs while not granted
    b4_req = 1; b4_we = 4'b0011; b4_addr = 8'd7; b4_idata = 32'h12345678;
    #1;
    chk("t2_gnt_idle", 64'(b4_gnt), 64'd1);
    tick();
    b4_req = 0; b4_we = 4'hF; b4_addr = 8'd0; b4_idata = 32'hFFFFFFFF;
    chk("t2_gnt_w1", 64'(b4_gnt), 64'd0);
    chk("t2_rvalid_w1", 64'(b4_rvalid), 64'd0);
    tick();
    chk("t2_gnt_w2", 64'(b4_gnt), 64'd0);
    tick();
    chk("t2_gnt_w3", 64'(b4_gnt), 64'd0);
    chk("t2_rvalid_w3", 64'(b4_rvalid), 64'd0);
    tick();
    chk("t2_rvalid", 64'(b4_rvalid), 64'd1);
    chk("t2_rdata_old", 64'(b4_rdata), 64'd0);
    chk("t2_err", 64'(b4_err), 64'd0);
    chk("t2_gnt_resp", 64'(b4_gnt), 64'd1);
    tick();
    chk("t2_rvalid_pulse", 64'(b4_rvalid), 64'd0);
    a4_en = 1; a4_we = '0; a4_addr = 8'd7;
    tick();
    chk("t2_a_result", 64'(a4_odata), 64'h00005678);

    // ENTRY=200: in-range read then out-of-range read
    b4_req = 1; b4_we = '0; b4_addr = 8'd7;
    tick();
    b4_req = 0;
    tick();
    tick();
    tick();
    chk("t4_rdata7", 64'(b4_rdata), 64'h00005678);
    b4_req = 1; b4_addr = 8'd250;
    tick();
    b4_req = 0;
    tick();
    tick();
    tick();
    chk("t4_oor_rvalid", 64'(b4_rvalid), 64'd1);
    chk("t4_oor_err", 64'(b4_err), 64'd1);
    chk("t4_oor_rdata", 64'(b4_rdata), 64'd0);
    a4_addr = 8'd250;
    tick();
    chk("t4_a_oor_odata", 64'(a4_odata), 64'd0);
    a4_en = 0;

    // LATENCY=3: normal read, then reset with a write outstanding
    b3_req = 1; b3_we = '0; b3_addr = 8'd2;
    tick();
    b3_req = 0;
    tick();
    chk("t5_rvalid_early", 64'(b3_rvalid), 64'd0);
    tick();
    chk("t5_rvalid", 64'(b3_rvalid), 64'd1);
    chk("t5_rdata", 64'(b3_rdata), 64'hCAFEF00D);
    a3_en = 1; a3_we = '0; a3_addr = 8'd2;
    tick();
    chk("t5_a_pre", 64'(a3_odata), 64'hCAFEF00D);
    a3_en = 0;
    b3_req = 1; b3_we = 4'hF; b3_addr = 8'd2; b3_idata = 32'h0;
    tick();
    b3_req = 0;
    rst3_n = 0;
    a3_en = 1; a3_we = 4'hF; a3_addr = 8'd2; a3_idata = 32'h0;
    #1;
    chk("t5_gnt_in_rst", 64'(b3_gnt), 64'd0);
    tick();
    chk("t5_rst_rvalid", 64'(b3_rvalid), 64'd0);
    chk("t5_rst_rdata", 64'(b3_rdata), 64'd0);
    chk("t5_rst_err", 64'(b3_err), 64'd0);
    chk("t5_rst_a_odata", 64'(a3_odata), 64'd0);
    a3_en = 0; a3_we = '0;
    rst3_n = 1;
    #1;
    chk("t5_gnt_after", 64'(b3_gnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_rvalid", 64'(b3_rvalid), 64'd0);
    end
    a3_en = 1; a3_addr = 8'd2;
    tick();
    chk("t5_mem_kept", 64'(a3_odata), 64'hCAFEF00D);
    a3_en = 0;

    // WIDTH=64: write only byte 7
    b64_req = 1; b64_we = 8'h80; b64_addr = 8'd1; b64_idata = 64'hFF00000000000000;
    tick();
    chk("t6_rvalid", 64'(b64_rvalid), 64'd1);
    chk("t6_rdata_old", b64_rdata, 64'h0123456789ABCDEF);
    b64_req = 0; b64_we = '0;
    a64_en = 1; a64_addr = 8'd1;
    tick();
    chk("t6_byte7", a64_odata, 64'hFF23456789ABCDEF);
    a64_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
